// File: rtl/clink_pkg.sv
// Shared types and defaults for the Camera Link frame packer.
package clink_pkg;

  localparam int TAPS_DEF      = 3;
  localparam int OUT_BYTES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  // One AXI4-Stream beat as held in the output register.
  typedef struct packed {
    logic [OUT_BYTES_DEF*8-1:0] data;
    logic [OUT_BYTES_DEF-1:0]   keep;
    logic                       last;
    logic                       user;
  } axis_beat_t;

endpackage

// File: rtl/clink_byte_packer.sv
// Accumulates tap bytes into a shift buffer and emits full or tail beats.
// Beat outputs are combinational; the parent registers them.
module clink_byte_packer
  import clink_pkg::*;
#(
  parameter int TAPS      = TAPS_DEF,
  parameter int OUT_BYTES = OUT_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   sample,
  input  logic [TAPS*8-1:0]      taps,
  input  logic                   flush,
  output logic                   beat_vld,
  output logic [OUT_BYTES*8-1:0] beat_data,
  output logic [OUT_BYTES-1:0]   beat_keep,
  output logic                   beat_last
);

  localparam int BUF_B  = OUT_BYTES + TAPS - 1;
  localparam int FILL_W = $clog2(BUF_B + 1);
  localparam logic [FILL_W-1:0] TAPS_F = FILL_W'(TAPS);
  localparam logic [FILL_W-1:0] OUT_F  = FILL_W'(OUT_BYTES);

  logic [BUF_B*8-1:0] buf_q;
  logic [BUF_B*8-1:0] buf_wr;
  logic [BUF_B*8-1:0] buf_nxt;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_sum;
  logic [FILL_W-1:0]  fill_nxt;
  logic               full;

  // Append the taps at the fill point and decide whether a beat leaves this cycle.
  always_comb begin
    buf_wr = buf_q;
    for (int i = 0; i < TAPS; i++) begin
      buf_wr[(int'(fill_q) + i)*8 +: 8] = taps[i*8 +: 8];
    end
    fill_sum  = fill_q + TAPS_F;
    full      = (fill_sum >= OUT_F);
    beat_vld  = 1'b0;
    beat_data = '0;
    beat_keep = '0;
    beat_last = 1'b0;
    buf_nxt   = buf_q;
    fill_nxt  = fill_q;
    if (flush) begin
      // Tail beat: only the filled bytes are kept, the rest forced to zero.
      // An empty buffer yields a null beat that still carries tlast.
      beat_vld  = 1'b1;
      beat_last = 1'b1;
      for (int b = 0; b < OUT_BYTES; b++) begin
        if (b < int'(fill_q)) begin
          beat_keep[b]         = 1'b1;
          beat_data[b*8 +: 8]  = buf_q[b*8 +: 8];
        end
      end
      buf_nxt  = '0;
      fill_nxt = '0;
    end else if (sample) begin
      if (full) begin
        beat_vld  = 1'b1;
        beat_keep = '1;
        beat_data = buf_wr[OUT_BYTES*8-1:0];
        buf_nxt   = buf_wr >> (OUT_BYTES*8);
        fill_nxt  = fill_sum - OUT_F;
      end else begin
        buf_nxt  = buf_wr;
        fill_nxt = fill_sum;
      end
    end
  end

  // Buffer and fill count; cleared on reset and at each start of frame.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_nxt;
      fill_q <= fill_nxt;
    end
  end

endmodule

// File: rtl/clink_frame_packer.sv
// Camera Link X-channel frame capture: whole-frame FSM, geometry measurement
// and a single-entry AXI4-Stream output register fed by clink_byte_packer.
module clink_frame_packer
  import clink_pkg::*;
#(
  parameter int TAPS      = TAPS_DEF,
  parameter int OUT_BYTES = OUT_BYTES_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                   px_clk,
  input  logic                   reset,
  input  logic [7:0]             d0,
  input  logic [7:0]             d1,
  input  logic [7:0]             d2,
  input  logic                   lval,
  input  logic                   fval,
  input  logic                   dval,
  input  logic                   px_ready,
  input  logic                   capture_en,
  output logic [OUT_BYTES*8-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   image_end,
  output logic [CNT_W-1:0]       frame_width,
  output logic [CNT_W-1:0]       frame_height,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   line_err,
  output logic                   overflow
);

  state_t                 state;
  logic                   fval_q;
  logic                   lval_q;
  logic                   sof_q;
  logic [CNT_W-1:0]       pix_cnt;
  logic [CNT_W-1:0]       line_cnt;
  logic                   sample;
  logic                   sof_start;
  logic                   line_end;
  logic                   flush;
  logic                   can_load;
  logic                   beat_vld;
  logic [OUT_BYTES*8-1:0] beat_data;
  logic [OUT_BYTES-1:0]   beat_keep;
  logic                   beat_last;
  axis_beat_t             out_p1;
  logic                   vld_p1;

  assign sample    = (state == CAPTURE) & px_ready & fval & lval & dval;
  assign sof_start = (state == ARMED) & capture_en & fval & ~fval_q;
  assign line_end  = (state == CAPTURE) & lval_q & ~lval;
  assign flush     = (state == FLUSH);
  assign can_load  = ~vld_p1 | m_axis_tready;

  clink_byte_packer #(
    .TAPS      (TAPS),
    .OUT_BYTES (OUT_BYTES)
  ) u_packer (
    .clk       (px_clk),
    .reset     (reset),
    .clr       (sof_start),
    .sample    (sample),
    .taps      ({d2, d1, d0}),
    .flush     (flush),
    .beat_vld  (beat_vld),
    .beat_data (beat_data),
    .beat_keep (beat_keep),
    .beat_last (beat_last)
  );

  // Frame FSM plus line/pixel geometry counters and frame statistics.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state        <= IDLE;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_cnt    <= '0;
      line_err     <= 1'b0;
      image_end    <= 1'b0;
    end else begin
      fval_q    <= fval;
      lval_q    <= lval;
      image_end <= 1'b0;
      case (state)
        IDLE: begin
          // Only arm between frames so a frame in progress is never captured.
          if (capture_en && !fval) state <= ARMED;
        end
        ARMED: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (sof_start) begin
            state    <= CAPTURE;
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_err <= 1'b0;
          end
        end
        CAPTURE: begin
          if (line_end) begin
            pix_cnt <= '0;
            // Empty lines are ignored; the first counted line sets the width.
            if (pix_cnt != '0) begin
              if (line_cnt != '1) line_cnt <= line_cnt + CNT_W'(1);
              if (line_cnt == '0) frame_width <= pix_cnt;
              else if (pix_cnt != frame_width) line_err <= 1'b1;
            end
          end else if (sample && pix_cnt != '1) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
          if (!fval) state <= FLUSH;
        end
        FLUSH: begin
          frame_height <= line_cnt;
          image_end    <= 1'b1;
          frame_cnt    <= frame_cnt + CNT_W'(1);
          state        <= capture_en ? ARMED : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: output register; beats that cannot be loaded are dropped ----
  always_ff @(posedge px_clk) begin
    if (reset) begin
      out_p1   <= '0;
      vld_p1   <= 1'b0;
      sof_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (vld_p1 && m_axis_tready) vld_p1 <= 1'b0;
      if (sof_start) sof_q <= 1'b1;
      if (beat_vld) begin
        if (can_load) begin
          out_p1.data <= beat_data;
          out_p1.keep <= beat_keep;
          out_p1.last <= beat_last;
          out_p1.user <= sof_q;
          vld_p1      <= 1'b1;
          sof_q       <= 1'b0;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign m_axis_tdata  = out_p1.data;
  assign m_axis_tkeep  = out_p1.keep;
  assign m_axis_tlast  = out_p1.last;
  assign m_axis_tuser  = out_p1.user;
  assign m_axis_tvalid = vld_p1;

endmodule
